// File: rtl/core_pkg.sv
// Shared definitions for the RV32I multi-cycle control sequencer:
// state encodings, next-PC operation codes and decoder MemOp bit positions.
package core_pkg;

  // Sequencer states. The numeric values are visible on the debug State port.
  typedef enum logic [3:0] {
    S_RESET      = 4'd0,
    S_FETCH      = 4'd1,
    S_FETCH_WAIT = 4'd2,
    S_DECODE     = 4'd3,
    S_REGREAD    = 4'd4,
    S_EXEC       = 4'd5,
    S_MEM        = 4'd6,
    S_MEM_WAIT   = 4'd7,
    S_WRITEBACK  = 4'd8,
    S_HALT       = 4'd9,
    S_FAULT      = 4'd10
  } state_t;

  // Next-PC operations understood by the pc unit.
  localparam logic [1:0] PC_HOLD   = 2'b00;
  localparam logic [1:0] PC_INC    = 2'b01;
  localparam logic [1:0] PC_BRANCH = 2'b10;
  localparam logic [1:0] PC_RESET  = 2'b11;
  localparam logic [1:0] PC_INTVEC = 2'b11;

  // Decoder MemOp field: bit 4 marks a memory instruction, bit 3 a store.
  localparam int MEMOP_VALID = 4;
  localparam int MEMOP_STORE = 3;

  // True in the two states that wait on the memory controller.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH_WAIT) || (s == S_MEM_WAIT);
  endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Command/response handshake between the sequencer and the memory controller.
interface core_sequencer_if;

  logic MemReady;      // controller can accept a command
  logic MemDataReady;  // outstanding transaction complete
  logic MemExecute;    // one-cycle command pulse
  logic MemWe;         // write qualifier, valid with MemExecute

  // The sequencer issues commands.
  modport master (
    output MemExecute,
    output MemWe,
    input  MemReady,
    input  MemDataReady
  );

  // The memory controller services them.
  modport slave (
    input  MemExecute,
    input  MemWe,
    output MemReady,
    output MemDataReady
  );

endinterface

// File: rtl/seq_watchdog.sv
// Memory-transaction watchdog. Counts cycles while enabled and flags expiry
// on the cycle that would bring the count up to LIMIT. Because expire is
// qualified by en, a completion arriving in the expiry cycle (which drops en)
// always beats the timeout.
module seq_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic srst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count_reg;

  // Count idle wait cycles; cleared whenever the owner is not waiting.
  always_ff @(posedge clk) begin
    if (srst || clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expire = en && (count_reg == LAST);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the RV32I core. Walks each instruction through
// fetch, decode, register read, execute, optional memory access and
// writeback, driving stage enables and the next-PC operation. Every control
// output is a register loaded on the edge that enters the state it belongs
// to, so the outputs are clean decodes of the current state with no
// combinational path from inputs. Interrupts are taken only on entry to
// WRITEBACK and halt requests only in FETCH; stuck memory transactions are
// trapped by a watchdog into a sticky FAULT state. MEM_TIMEOUT must be >= 2.
module core_sequencer
  import core_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Halt,
  input  logic                    Int,
  output logic                    IntAck,
  input  logic                    TrapExit,
  input  logic                    RegDwe,
  input  logic [4:0]              MemOp,
  input  logic                    AluWait,
  input  logic                    ShouldBranch,
  core_sequencer_if.master        mem,
  output logic                    InstLatch,
  output logic                    DecodeEn,
  output logic                    RegRead,
  output logic                    AluEn,
  output logic                    RegWrite,
  output logic                    EpcWe,
  output logic [1:0]              PcOp,
  output logic                    Halted,
  output logic                    Fault,
  output logic [31:0]             Retired,
  output logic [3:0]              State
);

  state_t      state_reg;
  logic        mem_execute_reg;
  logic        mem_we_reg;
  logic        inst_latch_reg;
  logic        decode_en_reg;
  logic        reg_read_reg;
  logic        alu_en_reg;
  logic        reg_write_reg;
  logic        epc_we_reg;
  logic        int_ack_reg;
  logic [1:0]  pc_op_reg;
  logic        halted_reg;
  logic        fault_reg;
  logic [31:0] retired_reg;
  logic        int_en_reg;

  logic        in_wait;
  logic        wd_clr;
  logic        wd_en;
  logic        wd_expire;
  logic        enter_wb;
  logic        take_int;
  logic [1:0]  wb_pc_op;

  // Only the valid and store bits of MemOp matter to sequencing; the access
  // size bits are consumed by the memory controller directly.
  logic unused_memop;
  assign unused_memop = ^MemOp[2:0];

  // The watchdog runs only while a memory transaction is outstanding and is
  // held clear in every other state, so each wait state starts from zero.
  assign in_wait = is_wait_state(state_reg);
  assign wd_clr  = !in_wait;
  assign wd_en   = in_wait && !mem.MemDataReady;

  seq_watchdog #(
    .LIMIT (MEM_TIMEOUT)
  ) u_watchdog (
    .clk    (Clk),
    .srst   (Reset),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_expire)
  );

  // Writeback entry conditions and the retirement decisions made on that
  // edge. A trap return blocks interrupt entry for this instruction so the
  // handler's own return retires before the next interrupt is taken.
  always_comb begin
    enter_wb = 1'b0;
    if ((state_reg == S_EXEC) && !AluWait && !MemOp[MEMOP_VALID]) begin
      enter_wb = 1'b1;
    end
    if ((state_reg == S_MEM_WAIT) && mem.MemDataReady) begin
      enter_wb = 1'b1;
    end
    take_int = Int && int_en_reg && !TrapExit;
    if (take_int) begin
      wb_pc_op = PC_INTVEC;
    end else if (ShouldBranch) begin
      wb_pc_op = PC_BRANCH;
    end else begin
      wb_pc_op = PC_INC;
    end
  end

  // State transitions together with the registered outputs of the next state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg       <= S_RESET;
      mem_execute_reg <= 1'b0;
      mem_we_reg      <= 1'b0;
      inst_latch_reg  <= 1'b0;
      decode_en_reg   <= 1'b0;
      reg_read_reg    <= 1'b0;
      alu_en_reg      <= 1'b0;
      reg_write_reg   <= 1'b0;
      epc_we_reg      <= 1'b0;
      int_ack_reg     <= 1'b0;
      pc_op_reg       <= PC_RESET;
      halted_reg      <= 1'b0;
      fault_reg       <= 1'b0;
      retired_reg     <= '0;
      int_en_reg      <= 1'b1;
    end else begin
      // Pulses and stage enables default low, PC defaults to hold.
      mem_execute_reg <= 1'b0;
      mem_we_reg      <= 1'b0;
      inst_latch_reg  <= 1'b0;
      decode_en_reg   <= 1'b0;
      reg_read_reg    <= 1'b0;
      alu_en_reg      <= 1'b0;
      reg_write_reg   <= 1'b0;
      epc_we_reg      <= 1'b0;
      int_ack_reg     <= 1'b0;
      pc_op_reg       <= PC_HOLD;
      halted_reg      <= 1'b0;
      fault_reg       <= 1'b0;

      case (state_reg)
        S_RESET: begin
          state_reg <= S_FETCH;
        end

        S_FETCH: begin
          if (Halt) begin
            state_reg  <= S_HALT;
            halted_reg <= 1'b1;
          end else if (mem.MemReady) begin
            state_reg       <= S_FETCH_WAIT;
            mem_execute_reg <= 1'b1;
          end
        end

        S_FETCH_WAIT: begin
          if (mem.MemDataReady) begin
            state_reg      <= S_DECODE;
            inst_latch_reg <= 1'b1;
            decode_en_reg  <= 1'b1;
          end else if (wd_expire) begin
            state_reg <= S_FAULT;
            fault_reg <= 1'b1;
          end
        end

        S_DECODE: begin
          state_reg    <= S_REGREAD;
          reg_read_reg <= 1'b1;
        end

        S_REGREAD: begin
          state_reg  <= S_EXEC;
          alu_en_reg <= 1'b1;
        end

        // The non-memory exit to WRITEBACK is handled by enter_wb below.
        S_EXEC: begin
          if (AluWait) begin
            alu_en_reg <= 1'b1;
          end else if (MemOp[MEMOP_VALID]) begin
            state_reg <= S_MEM;
          end
        end

        // MemOp is held by the decoder, so the store bit is read directly.
        S_MEM: begin
          if (mem.MemReady) begin
            state_reg       <= S_MEM_WAIT;
            mem_execute_reg <= 1'b1;
            mem_we_reg      <= MemOp[MEMOP_STORE];
          end
        end

        // Completion exits through enter_wb; only the timeout is handled here.
        S_MEM_WAIT: begin
          if (!mem.MemDataReady && wd_expire) begin
            state_reg <= S_FAULT;
            fault_reg <= 1'b1;
          end
        end

        S_WRITEBACK: begin
          state_reg <= S_FETCH;
        end

        // Resume fetching at the same PC once the request drops.
        S_HALT: begin
          if (Halt) begin
            halted_reg <= 1'b1;
          end else begin
            state_reg <= S_FETCH;
          end
        end

        S_FAULT: begin
          fault_reg <= 1'b1;
        end

        default: begin
          state_reg <= S_FAULT;
          fault_reg <= 1'b1;
        end
      endcase

      // Retire the instruction on the edge that enters WRITEBACK.
      if (enter_wb) begin
        state_reg     <= S_WRITEBACK;
        reg_write_reg <= RegDwe;
        retired_reg   <= retired_reg + 32'd1;
        pc_op_reg     <= wb_pc_op;
        int_ack_reg   <= take_int;
        epc_we_reg    <= take_int;
        if (take_int) begin
          int_en_reg <= 1'b0;
        end else if (TrapExit) begin
          int_en_reg <= 1'b1;
        end
      end
    end
  end

  assign mem.MemExecute = mem_execute_reg;
  assign mem.MemWe      = mem_we_reg;
  assign IntAck         = int_ack_reg;
  assign InstLatch      = inst_latch_reg;
  assign DecodeEn       = decode_en_reg;
  assign RegRead        = reg_read_reg;
  assign AluEn          = alu_en_reg;
  assign RegWrite       = reg_write_reg;
  assign EpcWe          = epc_we_reg;
  assign PcOp           = pc_op_reg;
  assign Halted         = halted_reg;
  assign Fault          = fault_reg;
  assign Retired        = retired_reg;
  assign State          = state_reg;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: a memory/ALU/decoder environment plus an
// instruction-level reference model that predicts per-instruction cycle
// counts, stage pulse counts, next-PC choice, interrupt entry and retirement.
module tb_core_sequencer;

  localparam int TIMEOUT = 4;
  localparam int NEVER   = 1000;

  // State codes as published on the debug port.
  localparam int ST_RESET = 0;
  localparam int ST_FETCH = 1;
  localparam int ST_FWAIT = 2;
  localparam int ST_MWAIT = 7;
  localparam int ST_WB    = 8;
  localparam int ST_HALT  = 9;
  localparam int ST_FAULT = 10;

  logic        Clk = 1'b0;
  logic        Reset, Halt, Int, TrapExit, RegDwe, AluWait, ShouldBranch;
  logic [4:0]  MemOp;
  logic        IntAck, InstLatch, DecodeEn, RegRead, AluEn, RegWrite, EpcWe;
  logic [1:0]  PcOp;
  logic        Halted, Fault;
  logic [31:0] Retired;
  logic [3:0]  State;

  core_sequencer_if mem_bus ();

  core_sequencer #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Reset(Reset), .Halt(Halt), .Int(Int), .IntAck(IntAck),
    .TrapExit(TrapExit), .RegDwe(RegDwe), .MemOp(MemOp), .AluWait(AluWait),
    .ShouldBranch(ShouldBranch), .mem(mem_bus), .InstLatch(InstLatch),
    .DecodeEn(DecodeEn), .RegRead(RegRead), .AluEn(AluEn), .RegWrite(RegWrite),
    .EpcWe(EpcWe), .PcOp(PcOp), .Halted(Halted), .Fault(Fault),
    .Retired(Retired), .State(State)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int model_retired = 0;
  bit model_int_en  = 1'b1;

  // Environment state.
  int rdy_hold, alu_hold, dr_count;
  bit dr_pending;
  int cur_fl, cur_ml, cur_aw, cur_busy;

  // Per-window observation counters.
  int cyc, n_memx, n_we, n_alu, n_latch, n_dec, n_rr, n_rw, n_ack, n_epc;
  int n_pcnz, n_halted, pc_wb;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    cyc = 0; n_memx = 0; n_we = 0; n_alu = 0; n_latch = 0; n_dec = 0; n_rr = 0;
    n_rw = 0; n_ack = 0; n_epc = 0; n_pcnz = 0; n_halted = 0; pc_wb = -1;
  endtask

  task automatic clear_env();
    rdy_hold = 0; alu_hold = 0; dr_count = 0; dr_pending = 1'b0;
    mem_bus.MemReady = 1'b1; mem_bus.MemDataReady = 1'b0; AluWait = 1'b0;
  endtask

  // One clock: observe this cycle's outputs, then drive this cycle's inputs.
  // Memory answers each command after a programmed number of idle cycles;
  // after a fetch completes it stays busy for cur_busy cycles and the ALU
  // reports busy long enough to cover cur_aw EXEC cycles.
  task automatic step();
    @(posedge Clk);
    #1;
    cyc++;
    if (mem_bus.MemExecute) begin
      n_memx++;
      if (mem_bus.MemWe) n_we++;
    end
    if (AluEn)     n_alu++;
    if (InstLatch) n_latch++;
    if (DecodeEn)  n_dec++;
    if (RegRead)   n_rr++;
    if (RegWrite)  n_rw++;
    if (IntAck)    n_ack++;
    if (EpcWe)     n_epc++;
    if (PcOp != 2'b00) n_pcnz++;
    if (Halted)    n_halted++;
    if (State == 4'(ST_WB)) pc_wb = int'(PcOp);

    mem_bus.MemReady = (rdy_hold == 0);
    if (rdy_hold > 0) rdy_hold--;
    AluWait = (alu_hold > 0);
    if (alu_hold > 0) alu_hold--;
    mem_bus.MemDataReady = 1'b0;
    if (mem_bus.MemExecute) begin
      dr_pending = 1'b1;
      dr_count   = (n_memx == 1) ? cur_fl : cur_ml;
    end
    if (dr_pending) begin
      if (dr_count == 0) begin
        mem_bus.MemDataReady = 1'b1;
        dr_pending = 1'b0;
        if (n_memx == 1) begin
          rdy_hold = cur_busy;
          alu_hold = (cur_aw > 0) ? cur_aw + 2 : 0;
        end
      end else begin
        dr_count--;
      end
    end
  endtask

  // Run one instruction from its first FETCH cycle through WRITEBACK.
  // fd: cycles MemReady is low in FETCH; fl/ml: idle cycles before fetch /
  // data completion; aw: extra EXEC cycles; busy: controller busy after fetch.
  task automatic run_instr(input int fd, input int fl, input int aw, input int busy,
                           input int ml, input bit is_mem, input bit st, input bit dwe,
                           input bit br, input bit intr, input bit trap, input bit halt_mid);
    int exp_cycles, m_cycles, guard, exp_pc;
    bit take;
    cur_fl = fl; cur_ml = ml; cur_aw = aw; cur_busy = busy;
    rdy_hold = fd;
    MemOp = {is_mem, st, 3'($urandom_range(0, 7))};
    RegDwe = dwe; ShouldBranch = br; Int = intr; TrapExit = trap;
    clear_counts();

    m_cycles = busy - aw - 2;
    if (m_cycles < 1) m_cycles = 1;
    exp_cycles = (1 + fd) + (fl + 1) + 2 + (1 + aw) + 1;
    if (is_mem) exp_cycles += m_cycles + ml + 1;

    step();
    check_eq("first_state", State, ST_FETCH);
    check_eq("retired", Retired, model_retired);
    guard = 0;
    while (State != 4'(ST_WB) && guard < 200) begin
      if (halt_mid && AluEn) Halt = 1'b1;
      step();
      guard++;
    end
    check_eq("wb_state", State, ST_WB);

    take = intr && model_int_en && !trap;
    if (take) model_int_en = 1'b0;
    else if (trap) model_int_en = 1'b1;
    model_retired++;
    exp_pc = take ? 3 : (br ? 2 : 1);

    check_eq("cycles", cyc, exp_cycles);
    check_eq("alu_en_cycles", n_alu, 1 + aw);
    check_eq("mem_execute", n_memx, is_mem ? 2 : 1);
    check_eq("mem_we", n_we, (is_mem && st) ? 1 : 0);
    check_eq("inst_latch", n_latch, 1);
    check_eq("decode_en", n_dec, 1);
    check_eq("reg_read", n_rr, 1);
    check_eq("reg_write", n_rw, dwe ? 1 : 0);
    check_eq("int_ack", n_ack, take ? 1 : 0);
    check_eq("epc_we", n_epc, take ? 1 : 0);
    check_eq("pc_op_wb", pc_wb, exp_pc);
    check_eq("pc_op_nonhold", n_pcnz, 1);
    check_eq("halted", n_halted, 0);
    $display("instr %0d: mem=%0d st=%0d dwe=%0d br=%0d int=%0d trap=%0d aw=%0d cycles=%0d pc_op=%0d ack=%0d",
             model_retired, is_mem, st, dwe, br, intr, trap, aw, cyc, pc_wb, n_ack);
  endtask

  // Apply a one-cycle reset from any state and check the reset outputs.
  task automatic do_reset(input string tag);
    Reset = 1'b1;
    step();
    check_eq({tag, "_state"}, State, ST_RESET);
    check_eq({tag, "_pc_op"}, PcOp, 3);
    check_eq({tag, "_retired"}, Retired, 0);
    check_eq({tag, "_fault"}, Fault, 0);
    check_eq({tag, "_memx"}, mem_bus.MemExecute, 0);
    Reset = 1'b0;
    clear_env();
    model_retired = 0;
    model_int_en  = 1'b1;
    $display("reset %s: state=%0d pc_op=%0d retired=%0d", tag, State, PcOp, Retired);
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      run_instr($urandom_range(0, 2), $urandom_range(0, TIMEOUT - 1), $urandom_range(0, 3),
                $urandom_range(0, 7), $urandom_range(0, TIMEOUT - 1),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 3) == 0), 1'b0);
    end
  endtask

  initial begin
    int waits, guard;
    Reset = 1'b1; Halt = 1'b0; Int = 1'b0; TrapExit = 1'b0; RegDwe = 1'b0;
    ShouldBranch = 1'b0; MemOp = 5'd0;
    clear_env();
    clear_counts();
    mem_bus.MemReady = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check_eq("rst_state", State, ST_RESET);
    check_eq("rst_pc_op", PcOp, 3);
    check_eq("rst_retired", Retired, 0);
    check_eq("rst_fault", Fault, 0);
    check_eq("rst_halted", Halted, 0);
    check_eq("rst_memx", mem_bus.MemExecute, 0);
    $display("reset initial: state=%0d pc_op=%0d", State, PcOp);
    Reset = 1'b0;
    clear_env();

    // ALU instruction, data two cycles after the command.
    run_instr(0, 1, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // Store with three ALU busy cycles.
    run_instr(0, 1, 3, 0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Load held off in MEM by a busy controller.
    run_instr(1, 0, 0, 6, 2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // Branch taken, then branch with interrupt, then a second interrupt
    // (ignored), trap return with interrupt (ignored), then interrupt taken.
    run_instr(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_instr(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    run_instr(0, 2, 1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    run_instr(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    run_instr(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    // Data on the last allowed wait cycle of both fetch and memory.
    run_instr(0, TIMEOUT - 1, 0, 0, TIMEOUT - 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Halt raised mid-EXEC: instruction completes, then HALT from FETCH.
    run_instr(0, 0, 2, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    check_eq("halt_fetch", State, ST_FETCH);
    clear_counts();
    Int = 1'b1;
    repeat (5) step();
    check_eq("halt_state", State, ST_HALT);
    check_eq("halt_cycles", n_halted, 5);
    check_eq("halt_memx", n_memx, 0);
    check_eq("halt_int_ack", n_ack, 0);
    check_eq("halt_pc_op", n_pcnz, 0);
    $display("halt: cycles=%0d memx=%0d ack=%0d", n_halted, n_memx, n_ack);
    Halt = 1'b0;
    run_instr(0, 1, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    run_random(40);

    // Fetch that never completes: FAULT after TIMEOUT wait cycles, sticky.
    cur_fl = NEVER; cur_ml = NEVER; cur_aw = 0; cur_busy = 0; rdy_hold = 0;
    clear_counts();
    step();
    check_eq("to_fetch", State, ST_FETCH);
    waits = 0;
    guard = 0;
    step();
    while (State == 4'(ST_FWAIT) && guard < 20) begin
      waits++;
      guard++;
      step();
    end
    check_eq("to_waits", waits, TIMEOUT);
    check_eq("to_state", State, ST_FAULT);
    check_eq("to_fault", Fault, 1);
    clear_counts();
    repeat (6) step();
    check_eq("to_sticky_state", State, ST_FAULT);
    check_eq("to_sticky_fault", Fault, 1);
    check_eq("to_sticky_memx", n_memx, 0);
    $display("timeout: waits=%0d state=%0d fault=%0d", waits, State, Fault);
    do_reset("after_fault");

    run_random(3);

    // Reset while a data access is outstanding in MEM_WAIT.
    cur_fl = 0; cur_ml = NEVER; cur_aw = 0; cur_busy = 0; rdy_hold = 0;
    MemOp = 5'b10000; Int = 1'b0; TrapExit = 1'b0; Halt = 1'b0;
    clear_counts();
    guard = 0;
    step();
    while (State != 4'(ST_MWAIT) && guard < 40) begin
      guard++;
      step();
    end
    check_eq("rmw_reached", State, ST_MWAIT);
    do_reset("in_mem_wait");
    run_instr(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so a stuck run still reports.
  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
